// File: rtl/ysyx_22040237_idu_pipe.sv
// Pipelined instruction-decode stage: RV ALU/U/jump/ebreak decode, one-entry output register, jump redirect.
// Optional register scoreboard with RAW/WAW stall enabled by `define YSYX_22040237_IDU_SCOREBOARD_EN.
module ysyx_22040237_idu_pipe #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rs1_r_addr,
  output logic [4:0]      rs2_r_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            jump_valid,
  output logic [PC_W-1:0] jump_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_alu_op,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic            out_rd_w_en,
  output logic [4:0]      out_rd_w_addr,
  output logic            out_ebreak,
  output logic            out_illegal,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr
);

  localparam logic [7:0]  ALU_NONE   = 8'h00;
  localparam logic [7:0]  ALU_ADD    = 8'h11;
  localparam logic [7:0]  ALU_SUB    = 8'h12;
  localparam logic [6:0]  OP_IMM     = 7'b0010011;
  localparam logic [6:0]  OP_REG     = 7'b0110011;
  localparam logic [6:0]  OP_LUI     = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC   = 7'b0010111;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;
  localparam logic [6:0]  OP_JALR    = 7'b1100111;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] imm_i, imm_u, imm_j, pc_x;
  logic            is_addi, is_add, is_sub, is_lui, is_auipc, is_jal, is_jalr, is_ebreak;
  logic            dec_legal, uses_rs1, uses_rs2;
  logic [7:0]      dec_alu_op;
  logic [XLEN-1:0] dec_op1, dec_op2;
  logic            dec_rd_w_en;
  logic            hazard, accept;
  logic [XLEN-1:0] jal_tgt, jalr_tgt;

  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_alu_op_q, out_alu_op_d;
  logic [XLEN-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic            out_rd_w_en_q, out_rd_w_en_d;
  logic [4:0]      out_rd_w_addr_q, out_rd_w_addr_d;
  logic            out_ebreak_q, out_ebreak_d;
  logic            out_illegal_q, out_illegal_d;

  assign opcode     = in_inst[6:0];
  assign funct3     = in_inst[14:12];
  assign funct7     = in_inst[31:25];
  assign rd_addr    = in_inst[11:7];
  assign rs1_r_addr = in_inst[19:15];
  assign rs2_r_addr = in_inst[24:20];

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign pc_x  = XLEN'(in_pc);

  assign is_addi   = (opcode == OP_IMM) && (funct3 == 3'b000);
  assign is_add    = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub    = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
  assign is_ebreak = (in_inst == INST_EBREAK);

  assign dec_legal = is_addi | is_add | is_sub | is_lui | is_auipc | is_jal | is_jalr | is_ebreak;
  assign uses_rs1  = is_addi | is_add | is_sub | is_jalr;
  assign uses_rs2  = is_add | is_sub;

  // Operand and opcode selection; ebreak and illegal encodings leave operands at zero.
  always_comb begin
    dec_alu_op  = ALU_NONE;
    dec_op1     = '0;
    dec_op2     = '0;
    dec_rd_w_en = dec_legal & ~is_ebreak & (rd_addr != 5'd0);
    if (is_addi) begin
      dec_alu_op = ALU_ADD;
      dec_op1    = rs1_data;
      dec_op2    = imm_i;
    end else if (is_add || is_sub) begin
      dec_alu_op = is_sub ? ALU_SUB : ALU_ADD;
      dec_op1    = rs1_data;
      dec_op2    = rs2_data;
    end else if (is_lui) begin
      dec_alu_op = ALU_ADD;
      dec_op2    = imm_u;
    end else if (is_auipc) begin
      dec_alu_op = ALU_ADD;
      dec_op1    = pc_x;
      dec_op2    = imm_u;
    end else if (is_jal || is_jalr) begin
      dec_alu_op = ALU_ADD;
      dec_op1    = pc_x;
      dec_op2    = XLEN'(4);
    end
  end

`ifdef YSYX_22040237_IDU_SCOREBOARD_EN
  logic [31:0] sb_q, sb_d;
  logic [31:0] busy;

  // A register is busy if retired-pending in the scoreboard or sitting in the output register.
  always_comb begin
    busy = sb_q;
    if (out_valid_q && out_rd_w_en_q) begin
      busy = busy | (32'b1 << out_rd_w_addr_q);
    end
    busy[0] = 1'b0;
    hazard  = (uses_rs1 & busy[rs1_r_addr]) | (uses_rs2 & busy[rs2_r_addr]) |
              (dec_rd_w_en & busy[rd_addr]);
  end

  always_comb begin
    sb_d = sb_q;
    if (wb_en) begin
      sb_d[wb_addr] = 1'b0;
    end
    if (out_valid_q && out_ready && !flush && out_rd_w_en_q) begin
      sb_d[out_rd_w_addr_q] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end
`else
  logic unused_cfg;
  assign hazard     = 1'b0;
  assign unused_cfg = ^{wb_en, wb_addr, uses_rs1, uses_rs2};
`endif

  assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  assign jal_tgt     = pc_x + imm_j;
  assign jalr_tgt    = (rs1_data + imm_i) & ~XLEN'(1);
  assign jump_valid  = accept & (is_jal | is_jalr);
  assign jump_target = PC_W'(is_jal ? jal_tgt : jalr_tgt);

  always_comb begin
    out_valid_d     = out_valid_q;
    out_alu_op_d    = out_alu_op_q;
    out_op1_d       = out_op1_q;
    out_op2_d       = out_op2_q;
    out_rd_w_en_d   = out_rd_w_en_q;
    out_rd_w_addr_d = out_rd_w_addr_q;
    out_ebreak_d    = out_ebreak_q;
    out_illegal_d   = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d     = 1'b1;
      out_alu_op_d    = dec_alu_op;
      out_op1_d       = dec_op1;
      out_op2_d       = dec_op2;
      out_rd_w_en_d   = dec_rd_w_en;
      out_rd_w_addr_d = rd_addr;
      out_ebreak_d    = is_ebreak;
      out_illegal_d   = ~dec_legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_alu_op_q    <= '0;
      out_op1_q       <= '0;
      out_op2_q       <= '0;
      out_rd_w_en_q   <= 1'b0;
      out_rd_w_addr_q <= '0;
      out_ebreak_q    <= 1'b0;
      out_illegal_q   <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_alu_op_q    <= out_alu_op_d;
      out_op1_q       <= out_op1_d;
      out_op2_q       <= out_op2_d;
      out_rd_w_en_q   <= out_rd_w_en_d;
      out_rd_w_addr_q <= out_rd_w_addr_d;
      out_ebreak_q    <= out_ebreak_d;
      out_illegal_q   <= out_illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_alu_op    = out_alu_op_q;
  assign out_op1       = out_op1_q;
  assign out_op2       = out_op2_q;
  assign out_rd_w_en   = out_rd_w_en_q;
  assign out_rd_w_addr = out_rd_w_addr_q;
  assign out_ebreak    = out_ebreak_q;
  assign out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_ysyx_22040237_idu_pipe.sv
// Scoreboard bench for ysyx_22040237_idu_pipe: directed vectors, queue of expected outputs, decoupled monitor.
module tb_ysyx_22040237_idu_pipe;
  localparam int unsigned XLEN = 64;
  localparam int unsigned PC_W = 32;

  logic            clk, rst;
  logic            in_valid, in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_inst;
  logic [4:0]      rs1_r_addr, rs2_r_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            jump_valid;
  logic [PC_W-1:0] jump_target;
  logic            out_valid, out_ready;
  logic [7:0]      out_alu_op;
  logic [XLEN-1:0] out_op1, out_op2;
  logic            out_rd_w_en;
  logic [4:0]      out_rd_w_addr;
  logic            out_ebreak, out_illegal;
  logic            flush, wb_en;
  logic [4:0]      wb_addr;

  ysyx_22040237_idu_pipe #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd_w_en(out_rd_w_en), .out_rd_w_addr(out_rd_w_addr),
    .out_ebreak(out_ebreak), .out_illegal(out_illegal),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr)
  );

  typedef struct {
    logic [7:0]  alu;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        wen;
    logic [4:0]  rd;
    logic        ebreak;
    logic        illegal;
    logic        ops_chk;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] alu, input logic [63:0] op1, input logic [63:0] op2,
                              input logic wen, input logic [4:0] rd, input logic eb, input logic ill,
                              input logic ops_chk, input string name);
    exp_t e;
    e.alu = alu; e.op1 = op1; e.op2 = op2; e.wen = wen; e.rd = rd;
    e.ebreak = eb; e.illegal = ill; e.ops_chk = ops_chk; e.name = name;
    return e;
  endfunction

  // Monitor: compare the held output against the queue head every cycle it is valid; pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = exp_q[0];
        chk({mon_e.name, "_alu_op"}, 64'(out_alu_op), 64'(mon_e.alu));
        chk({mon_e.name, "_rd_w_en"}, 64'(out_rd_w_en), 64'(mon_e.wen));
        chk({mon_e.name, "_ebreak"}, 64'(out_ebreak), 64'(mon_e.ebreak));
        chk({mon_e.name, "_illegal"}, 64'(out_illegal), 64'(mon_e.illegal));
        if (mon_e.ops_chk) begin
          chk({mon_e.name, "_op1"}, out_op1, mon_e.op1);
          chk({mon_e.name, "_op2"}, out_op2, mon_e.op2);
        end
        if (mon_e.wen) chk({mon_e.name, "_rd"}, 64'(out_rd_w_addr), 64'(mon_e.rd));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Present one instruction; expect acceptance after exactly exp_wait stall cycles.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [63:0] r1,
                       input logic [63:0] r2, input exp_t e, input int exp_wait,
                       input logic jmp, input logic [31:0] tgt);
    int  waited;
    bit  acc;
    waited = 0;
    acc    = 1'b0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(e);
        chk({e.name, "_jump_valid"}, 64'(jump_valid), 64'(jmp));
        if (jmp) chk({e.name, "_jump_target"}, 64'(jump_target), 64'(tgt));
      end else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    chk({e.name, "_stall_cycles"}, 64'(waited), 64'(exp_wait));
    if (acc) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; rs1_data = '0; rs2_data = '0;
    out_ready = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_alu_op", 64'(out_alu_op), 64'd0);
    chk("reset_op1", out_op1, 64'd0);
    chk("reset_op2", out_op2, 64'd0);
    chk("reset_rd_w_en", 64'(out_rd_w_en), 64'd0);
    chk("reset_ebreak", 64'(out_ebreak), 64'd0);
    chk("reset_illegal", 64'(out_illegal), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // addi x1, x0, 5
    issue(32'h00500093, 32'h80000000, 64'd0, 64'd0,
          mk(8'h11, 64'd0, 64'd5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, "addi_x1"), 0, 1'b0, 32'd0);
    #2 chk("addi_latency_out_valid", 64'(out_valid), 64'd1);
    #1;
    // add x3, x1, x2 right behind addi x1
`ifdef YSYX_22040237_IDU_SCOREBOARD_EN
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h80000008; rs1_data = 64'd5; rs2_data = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_x1_stall", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    wb_en = 1'b1; wb_addr = 5'd1;
    @(negedge clk);
    chk("raw_x1_stall_during_wb", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    wb_en = 1'b0;
`endif
    issue(32'h002081B3, 32'h80000008, 64'd5, 64'h1234,
          mk(8'h11, 64'd5, 64'h1234, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, "add_x3"), 0, 1'b0, 32'd0);

    // back-to-back stream, no hazards
    issue(32'h80000117, 32'h80000004, 64'd0, 64'd0,
          mk(8'h11, 64'h80000004, 64'hFFFFFFFF80000000, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, "auipc_x2"),
          0, 1'b0, 32'd0);
    issue(32'h010000EF, 32'h80000010, 64'd0, 64'd0,
          mk(8'h11, 64'h80000010, 64'd4, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, "jal_x1"),
          0, 1'b1, 32'h80000020);
    issue(32'h008302E7, 32'h80000020, 64'h80001003, 64'd0,
          mk(8'h11, 64'h80000020, 64'd4, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, "jalr_x5"),
          0, 1'b1, 32'h8000100A);
    issue(32'h123453B7, 32'h80000024, 64'd0, 64'd0,
          mk(8'h11, 64'd0, 64'h12345000, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, "lui_x7"), 0, 1'b0, 32'd0);
    issue(32'h40A48433, 32'h80000028, 64'd100, 64'd30,
          mk(8'h12, 64'd100, 64'd30, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, "sub_x8"), 0, 1'b0, 32'd0);
    issue(32'h00100073, 32'h8000002C, 64'd0, 64'd0,
          mk(8'h00, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, "ebreak"), 0, 1'b0, 32'd0);
    issue(32'h00100013, 32'h80000030, 64'd0, 64'd0,
          mk(8'h11, 64'd0, 64'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, "addi_x0"), 0, 1'b0, 32'd0);
    issue(32'hFFFFFFFF, 32'h80000034, 64'd0, 64'd0,
          mk(8'h00, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, "illegal"), 0, 1'b0, 32'd0);
    issue(32'hFFF00593, 32'h80000038, 64'd0, 64'd0,
          mk(8'h11, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1, "addi_neg1"),
          0, 1'b0, 32'd0);
    idle(2);

    // output back-pressure, then flush
    out_ready = 1'b0;
    issue(32'h00700613, 32'h80000040, 64'd0, 64'd0,
          mk(8'h11, 64'd0, 64'd7, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1, "addi_x12_held"), 0, 1'b0, 32'd0);
    in_valid = 1'b1; in_inst = 32'h000016B7; in_pc = 32'h80000044;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("backpressure_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    #2 chk("flush_out_valid", 64'(out_valid), 64'd0);
    #1;

    // reset mid-stall
    issue(32'h000016B7, 32'h80000044, 64'd0, 64'd0,
          mk(8'h11, 64'd0, 64'h1000, 1'b1, 5'd13, 1'b0, 1'b0, 1'b1, "lui_x13_held"), 0, 1'b0, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midstall_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midstall_rst_alu_op", 64'(out_alu_op), 64'd0);
    chk("midstall_rst_op1", out_op1, 64'd0);
    chk("midstall_rst_op2", out_op2, 64'd0);
    chk("midstall_rst_rd_w_en", 64'(out_rd_w_en), 64'd0);
    chk("midstall_rst_rd_w_addr", 64'(out_rd_w_addr), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // x2 and x3 were left pending before reset; a cleared scoreboard must not stall
    issue(32'h002081B3, 32'h80000050, 64'd9, 64'd6,
          mk(8'h11, 64'd9, 64'd6, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, "add_after_reset"), 0, 1'b0, 32'd0);
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
endmodule
